vedic_alu_seq: RTL

- Parametrised, handshaked successor to the 4-bit combinational Vedic add/multiply ALU.
- Supports add, subtract and multiply at any power-of-two width WIDTH >= 4.
- Multiply is iterative: one half-width Urdhva-Tiryagbhyam multiplier is reused over four cycles and the partial products are accumulated. This trades latency for area.
- Sits between an operand issue stage and a result consumer. Both sides use valid/ready.

---
 rtl/vedic_alu_pkg.sv | 20 ++
 rtl/vedic_mul_half.sv | 34 +++
 rtl/vedic_alu_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vedic_alu_pkg.sv
// Shared types and constants for the sequential Vedic add/sub/multiply ALU.
package vedic_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MUL  = 2'b01,
    OP_SUB  = 2'b10,
    OP_RSVD = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int MUL_STEPS = 4;
  localparam int STEP_W    = $clog2(MUL_STEPS);

endpackage

// File: rtl/vedic_mul_half.sv
// Combinational HALF x HALF Urdhva-Tiryagbhyam (vertically and crosswise) multiplier:
// each output column sums its crosswise bit products plus the carry from the column below.
module vedic_mul_half #(
  parameter int HALF = 4
) (
  input  logic [HALF-1:0]   x,
  input  logic [HALF-1:0]   y,
  output logic [2*HALF-1:0] p
);

  // Column sums never exceed 2*HALF-1, so this width cannot overflow.
  localparam int CW = $clog2(HALF) + 2;

  logic [CW-1:0] col;
  logic [CW-1:0] carry;

  always_comb begin
    p     = '0;
    col   = '0;
    carry = '0;
    for (int k = 0; k < 2*HALF-1; k++) begin
      col = carry;
      for (int i = 0; i < HALF; i++) begin
        for (int j = 0; j < HALF; j++) begin
          if (i + j == k) col = col + CW'(x[i] & y[j]);
        end
      end
      p[k]  = col[0];
      carry = col >> 1;
    end
    p[2*HALF-1] = carry[0];
  end

endmodule

// File: rtl/vedic_alu_seq.sv
// Handshaked add/sub/multiply ALU; multiply reuses one half-width Vedic multiplier
// over four cycles, accumulating the shifted partial products.
module vedic_alu_seq
  import vedic_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam int HALF = WIDTH / 2;

  state_e              state, state_d;
  opcode_e             op;
  logic                accept;
  logic                last_step;
  logic [STEP_W-1:0]   step;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [HALF-1:0]     mx, my;
  logic [WIDTH-1:0]    pp;
  logic [2*WIDTH-1:0]  term, acc, acc_d, result_q;
  logic                err_q;

  function automatic logic [2*WIDTH-1:0] add_ext(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {{(WIDTH-1){1'b0}}, s};
  endfunction

  // Bit WIDTH of the extended difference is the borrow (x < y).
  function automatic logic [2*WIDTH-1:0] sub_ext(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} - {1'b0, y};
    return {{(WIDTH-1){1'b0}}, s};
  endfunction

  assign op        = opcode_e'(opcode);
  assign accept    = in_valid && in_ready;
  assign last_step = (step == STEP_W'(MUL_STEPS - 1));
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign err       = err_q;

  // Step bit 1 picks the high half of A, step bit 0 the high half of B.
  always_comb begin
    mx = step[1] ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
    my = step[0] ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
  end

  vedic_mul_half #(.HALF(HALF)) u_mul (
    .x (mx),
    .y (my),
    .p (pp)
  );

  always_comb begin
    case (step)
      STEP_W'(0): term = {{WIDTH{1'b0}}, pp};
      STEP_W'(1),
      STEP_W'(2): term = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
      default:    term = {pp, {WIDTH{1'b0}}};
    endcase
    acc_d = acc + term;
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (op == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) state_d = (op == OP_MUL) ? MUL : DONE;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Accept stage: single-cycle ops land in result_q; multiply latches its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      step     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
      case (op)
        OP_ADD: result_q <= add_ext(a, b);
        OP_SUB: result_q <= sub_ext(a, b);
        OP_MUL: begin
          a_q  <= a;
          b_q  <= b;
          acc  <= '0;
          step <= '0;
        end
        default: begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      endcase
    end else if (state == MUL) begin
      // Multiply stage: one partial product per cycle, result published on the last.
      acc  <= acc_d;
      step <= step + STEP_W'(1);
      if (last_step) result_q <= acc_d;
    end
  end

endmodule
